// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch/jump flush, memory wait
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   id_valid             ID stage holds a real instruction
//   id_rs, id_rt         source register fields of the ID instruction
//   id_uses_rt           ID instruction reads rt
//   id_jump              ID instruction is a jump
//   ex_memread, ex_rt    EX instruction is a load and its destination
//   ex_branch_taken      branch in EX resolved taken
//   mem_req, mem_ready   MEM stage data-memory access / completion
//   pc_we, ifid_we       PC and IF/ID load enables
//   ifid_flush           IF/ID loads a zero instruction
//   idex_bubble          ID/EX control bits forced to zero
//   pipe_hold            freeze ID/EX, EX/MEM, MEM/WB
//   mem_err              sticky memory timeout flag
//   stall_cnt, flush_cnt saturating load-use stall / flush cycle counters
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              lu_block, lu_block_nxt;
  logic              load_use;
  logic              stall_inc, flush_inc;
  logic              pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c, pipe_hold_c;

  always_comb begin
    // lu_block masks the lw that already caused a stall, so a load in EX
    // that is still visible next cycle does not stall twice.
    load_use = ex_memread & id_valid & (ex_rt != 5'd0) & ~lu_block &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    state_nxt     = state;
    wait_nxt      = wait_cnt;
    lu_block_nxt  = lu_block;
    pc_we_c       = 1'b1;
    ifid_we_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    pipe_hold_c   = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (state)
      ERROR: begin
        pc_we_c     = 1'b0;
        ifid_we_c   = 1'b0;
        pipe_hold_c = 1'b1;
      end
      default: begin
        if (!mem_ready && (state == MEM_WAIT || mem_req)) begin
          // Held cycle: EX/ID inputs belong to frozen stages and are ignored.
          pc_we_c     = 1'b0;
          ifid_we_c   = 1'b0;
          pipe_hold_c = 1'b1;
          wait_nxt    = (state == RUN) ? WAIT_W'(1) : wait_cnt + WAIT_W'(1);
          state_nxt   = (wait_nxt >= WAIT_LIMIT) ? ERROR : MEM_WAIT;
        end else begin
          state_nxt    = RUN;
          wait_nxt     = '0;
          lu_block_nxt = 1'b0;
          if (ex_branch_taken) begin
            // Taken branch squashes the younger load-use and jump.
            ifid_we_c     = 1'b0;
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            flush_inc     = 1'b1;
          end else if (load_use) begin
            pc_we_c       = 1'b0;
            ifid_we_c     = 1'b0;
            idex_bubble_c = 1'b1;
            stall_inc     = 1'b1;
            lu_block_nxt  = 1'b1;
          end else if (id_jump) begin
            ifid_we_c    = 1'b0;
            ifid_flush_c = 1'b1;
            flush_inc    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      lu_block  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      lu_block <= lu_block_nxt;
      if (stall_inc && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Outputs are forced inactive while reset is asserted, without waiting for a clock.
  assign pc_we       = rst_n & pc_we_c;
  assign ifid_we     = rst_n & ifid_we_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign idex_bubble = rst_n & idex_bubble_c;
  assign pipe_hold   = rst_n & pipe_hold_c;
  assign mem_err     = rst_n & (state == ERROR);

endmodule
